clk_rst_gen: RTL and testbench
==============================

CLK_RST_GEN -- requirements
Module: clk_rst_gen

Interface
REQ-001 Parameter NUM_CH, default 4, number of generated clock/reset channels (1..16).
REQ-002 Parameter DIV_W, default 8, width of per-channel divide value.
REQ-003 Parameter HOLD_CYC, default 16, cycles all channel resets stay asserted after rst deasserts.
REQ-004 Parameter STAGGER, default 4, cycles between successive channel reset releases.
REQ-005 Parameter DEF_DIV, default 1, divide value loaded into every channel at reset.
REQ-006 Local constant CH_W = max(1, clog2(NUM_CH)).
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 cfg_valid  input  1  divide-update request.
REQ-010 cfg_ready  output  1  update accepted when cfg_valid and cfg_ready are both high at a clk edge.
REQ-011 cfg_ch  input  CH_W  target channel.
REQ-012 cfg_div  input  DIV_W  new divide value N.
REQ-013 ch_clk  output  NUM_CH  divided clock per channel.
REQ-014 ch_ce  output  NUM_CH  one-cycle clock-enable pulse per channel.
REQ-015 ch_rst_n  output  NUM_CH  active-low channel reset.
REQ-016 seq_done  output  1  high once all channel resets are released.

Function
REQ-017 Reset sequencer FSM states: ASSERT, HOLD, STAGGER, DONE.
REQ-018 ASSERT while rst is high; the first cycle with rst low moves to HOLD.
REQ-019 HOLD lasts exactly HOLD_CYC cycles, then moves to STAGGER.
REQ-020 In STAGGER, ch_rst_n[i] rises i*STAGGER cycles after HOLD exit; channel 0 rises on the first STAGGER cycle.
REQ-021 After ch_rst_n[NUM_CH-1] rises, move to DONE with seq_done=1 on the following cycle; DONE persists until rst.
REQ-022 Dividers run in every state except ASSERT: clocks toggle while channel resets are held.
REQ-023 Effective divide E = max(N,1); ch_ce[i] pulses for one cycle every E cycles.
REQ-024 ch_clk[i] toggles on every cycle ch_ce[i] is high; period = 2*E cycles; 50% duty.
REQ-025 cfg_ready = 1 in every state except ASSERT.
REQ-026 On an accepted update, the channel divide register takes cfg_div and the counter clears; ch_ce is suppressed that cycle; ch_clk keeps its level.
REQ-027 The first ch_ce after an update occurs E_new cycles after the accept edge.
REQ-028 An update with cfg_ch >= NUM_CH is handshaked and has no effect.
REQ-029 An update coinciding with a terminal count resolves as an update per REQ-026, with no pulse that cycle.

Reset
REQ-030 On rst: ch_clk=0, ch_ce=0, ch_rst_n=0, seq_done=0, cfg_ready=0, all divide registers=DEF_DIV, all counters=0, FSM=ASSERT.
REQ-031 rst asserted mid-operation takes effect at the next edge regardless of FSM state; the sequence restarts from ASSERT.

Configuration
REQ-032 Macro CLK_RST_GEN_GATE_EN, when defined, adds input ch_gate_en[NUM_CH]; a low bit freezes that channel's counter, forces ch_ce low, and holds ch_clk level.
REQ-033 Re-raising a gate bit resumes counting from the frozen value; gating does not affect ch_rst_n.
REQ-034 Without the macro, the port is absent and all channels run ungated.

Structure
REQ-035 Package clk_rst_gen_pkg holds the FSM state enum and default parameter constants.
REQ-036 Sub-module clk_div_ch implements one channel (divide register, counter, ce, clk toggle); it is instantiated NUM_CH times via generate.

Verification
REQ-037 Defaults, rst for 3 cycles then low -> all ch_rst_n low for 16 cycles; then ch_rst_n[0..3] rise at offsets 0,4,8,12; seq_done rises 1 cycle after ch_rst_n[3].
REQ-038 Update ch 2 with N=5 -> ch_ce[2] every 5 cycles, first pulse 5 cycles after accept; ch_clk[2] period 10.
REQ-039 Update with N=0 -> ch_ce continuous; ch_clk toggles every cycle (same as N=1).
REQ-040 Update arriving on a terminal-count cycle -> no pulse that cycle; next pulse E_new cycles later.
REQ-041 rst asserted during STAGGER after 2 releases -> next cycle all outputs at reset values; full sequence repeats.
REQ-042 With CLK_RST_GEN_GATE_EN, gate ch 1 low for 7 cycles with N=3 -> ch_clk[1] constant, no ch_ce[1]; after release, pulse spacing resumes from the frozen count.

Source files
------------

// File: rtl/clk_rst_gen_pkg.sv
// Shared types and default constants for the clock/reset generator.
//   seq_state_e : reset sequencer states
//   DEF_*       : default parameter values for clk_rst_gen / clk_div_ch
package clk_rst_gen_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_STAGGER = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_e;

    localparam int unsigned DEF_NUM_CH   = 4;
    localparam int unsigned DEF_DIV_W    = 8;
    localparam int unsigned DEF_HOLD_CYC = 16;
    localparam int unsigned DEF_STAGGER  = 4;
    localparam int unsigned DEF_DIV_VAL  = 1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: divide register, cycle counter, one-cycle
// clock-enable pulse and a 50% duty divided clock.
//   clk_i  : clock            rst_i : synchronous active-high reset
//   run_i  : counter advances (low freezes count, ce and clock level)
//   upd_i  : load div_i and restart the count (takes priority over a pulse)
//   div_i  : new divide value N, effective divide is max(N,1)
//   ce_o   : one-cycle pulse every effective-divide cycles
//   clk_o  : toggles on every ce pulse
module clk_div_ch
    import clk_rst_gen_pkg::*;
#(
    parameter int unsigned DIV_W   = DEF_DIV_W,
    parameter int unsigned DEF_DIV = DEF_DIV_VAL
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             upd_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             ce_o,
    output logic             clk_o
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             ce_q, ce_d;
    logic             dclk_q, dclk_d;
    logic [DIV_W-1:0] last_c;

    // Terminal count is E-1; N=0 behaves as N=1.
    assign last_c = (div_q == '0) ? '0 : div_q - DIV_W'(1);

    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        ce_d   = 1'b0;
        dclk_d = dclk_q;
        if (upd_i) begin
            div_d = div_i;
            cnt_d = '0;
        end else if (run_i) begin
            if (cnt_q == last_c) begin
                cnt_d  = '0;
                ce_d   = 1'b1;
                dclk_d = ~dclk_q;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q  <= DIV_W'(DEF_DIV);
            cnt_q  <= '0;
            ce_q   <= 1'b0;
            dclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            ce_q   <= ce_d;
            dclk_q <= dclk_d;
        end
    end

    assign ce_o  = ce_q;
    assign clk_o = dclk_q;

endmodule

// File: rtl/clk_rst_gen.sv
// Multi-channel clock-enable / divided-clock generator with a staggered
// reset-release sequencer.
//   clk, rst            : clock, synchronous active-high reset
//   cfg_valid/cfg_ready : divide-update handshake
//   cfg_ch, cfg_div     : target channel and new divide value
//   ch_clk, ch_ce       : per-channel divided clock and enable pulse
//   ch_rst_n            : per-channel active-low reset, released in order
//   seq_done            : all channel resets released
// Build option: define CLK_RST_GEN_GATE_EN to add ch_gate_en, a per-channel
// run enable that freezes a channel's divider while low.
module clk_rst_gen
    import clk_rst_gen_pkg::*;
#(
    parameter  int unsigned NUM_CH   = DEF_NUM_CH,
    parameter  int unsigned DIV_W    = DEF_DIV_W,
    parameter  int unsigned HOLD_CYC = DEF_HOLD_CYC,
    parameter  int unsigned STAGGER  = DEF_STAGGER,
    parameter  int unsigned DEF_DIV  = DEF_DIV_VAL,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
`ifdef CLK_RST_GEN_GATE_EN
    input  logic [NUM_CH-1:0] ch_gate_en,
`endif
    output logic [NUM_CH-1:0] ch_clk,
    output logic [NUM_CH-1:0] ch_ce,
    output logic [NUM_CH-1:0] ch_rst_n,
    output logic              seq_done
);

    localparam int unsigned REL_LAST = (NUM_CH - 1) * STAGGER;
    localparam int unsigned CNT_MAX  = max_u(HOLD_CYC, REL_LAST);
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 2);

    seq_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CH-1:0]   rst_n_q, rst_n_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic [NUM_CH-1:0]   rel_first_c;
    logic [NUM_CH-1:0]   rel_next_c;
    logic [NUM_CH-1:0]   gate_c;
    logic                accept_c;

`ifdef CLK_RST_GEN_GATE_EN
    assign gate_c = ch_gate_en;
`else
    assign gate_c = '1;
`endif

    // Release masks: channels due on STAGGER entry, and due on the next STAGGER cycle.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_rel
        localparam int unsigned REL_AT = 32'(g) * STAGGER;
        assign rel_first_c[g] = (REL_AT == 0);
        assign rel_next_c[g]  = ((32'(cnt_q) + 32'd1) >= REL_AT);
    end

    // Sequencer next state and outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_n_d = rst_n_q;
        done_d  = done_q;
        unique case (state_q)
            ST_ASSERT: begin
                cnt_d = '0;
                if (HOLD_CYC == 0) begin
                    state_d = ST_STAGGER;
                    rst_n_d = rel_first_c;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (32'(cnt_q) == HOLD_CYC - 32'd1) begin
                    state_d = ST_STAGGER;
                    cnt_d   = '0;
                    rst_n_d = rst_n_q | rel_first_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STAGGER: begin
                if (rst_n_q[NUM_CH-1]) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    rst_n_d = rst_n_q | rel_next_c;
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: state_d = ST_ASSERT;
        endcase
        ready_d = (state_d != ST_ASSERT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_n_q <= rst_n_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    // ready_q is high exactly when the sequencer has left ASSERT, so it also
    // serves as the divider run enable.
    assign accept_c = cfg_valid & ready_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk_i (clk),
            .rst_i (rst),
            .run_i (ready_q & gate_c[g]),
            .upd_i (accept_c && (cfg_ch == CH_W'(g))),
            .div_i (cfg_div),
            .ce_o  (ch_ce[g]),
            .clk_o (ch_clk[g])
        );
    end

    assign cfg_ready = ready_q;
    assign ch_rst_n  = rst_n_q;
    assign seq_done  = done_q;

endmodule

// File: tb/tb_clk_rst_gen.sv
// Directed bench for clk_rst_gen at default parameters. Expected values are
// queued with their target cycle when stimulus is applied and compared when
// that cycle's outputs are sampled. Define CLK_RST_GEN_GATE_EN for the gating step.
module tb_clk_rst_gen;

    localparam int NCH  = 4;
    localparam int HOLD = 16;
    localparam int STAG = 4;

    localparam int K_RSTN  = 0;
    localparam int K_DONE  = 1;
    localparam int K_READY = 2;
    localparam int K_CE    = 3;
    localparam int K_CLK   = 4;
    localparam int K_CEV   = 5;
    localparam int K_CLKV  = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_ch;
    logic [7:0]     cfg_div;
    logic [NCH-1:0] ch_gate_en;
    logic [NCH-1:0] ch_clk;
    logic [NCH-1:0] ch_ce;
    logic [NCH-1:0] ch_rst_n;
    logic           seq_done;

    typedef struct {
        int         cyc;
        int         kind;
        int         idx;
        logic [3:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    clk_rst_gen dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
`ifdef CLK_RST_GEN_GATE_EN
        .ch_gate_en (ch_gate_en),
`endif
        .ch_clk     (ch_clk),
        .ch_ce      (ch_ce),
        .ch_rst_n   (ch_rst_n),
        .seq_done   (seq_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] sample(input int kind, input int idx);
        case (kind)
            K_RSTN:  return ch_rst_n;
            K_DONE:  return {3'b000, seq_done};
            K_READY: return {3'b000, cfg_ready};
            K_CE:    return {3'b000, ch_ce[idx]};
            K_CLK:   return {3'b000, ch_clk[idx]};
            K_CEV:   return ch_ce;
            default: return ch_clk;
        endcase
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            K_RSTN:  return "ch_rst_n";
            K_DONE:  return "seq_done";
            K_READY: return "cfg_ready";
            K_CE:    return "ch_ce_bit";
            K_CLK:   return "ch_clk_bit";
            K_CEV:   return "ch_ce_vec";
            default: return "ch_clk_vec";
        endcase
    endfunction

    // Scoreboard consumer: compare every entry whose cycle has arrived.
    always @(negedge clk) begin
        logic [3:0] obs;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                obs = sample(sb[i].kind, sb[i].idx);
                checks++;
                assert (sb[i].cyc == cyc && obs === sb[i].val) else begin
                    errors++;
                    $error("FAIL %s[%0d] cyc=%0d observed=%b expected=%b (due cyc %0d)",
                           kname(sb[i].kind), sb[i].idx, cyc, obs, sb[i].val, sb[i].cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic push(input int c, input int kind, input int idx, input logic [3:0] val);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic to_cyc(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic push_reset_vals(input int c);
        push(c, K_RSTN, 0, 4'h0);
        push(c, K_DONE, 0, 4'h0);
        push(c, K_READY, 0, 4'h0);
        push(c, K_CEV, 0, 4'h0);
        push(c, K_CLKV, 0, 4'h0);
    endtask

    // Release schedule from the first edge with rst low (base), cut off at stop.
    task automatic push_seq(input int base, input int stop);
        logic [3:0] m;
        for (int c = base; c <= base + HOLD + (NCH - 1) * STAG + 4 && c < stop; c++) begin
            for (int i = 0; i < NCH; i++) m[i] = (c >= base + HOLD + i * STAG);
            push(c, K_RSTN, 0, m);
            push(c, K_DONE, 0, {3'b000, c >= base + HOLD + (NCH - 1) * STAG + 1});
            push(c, K_READY, 0, 4'h1);
        end
    endtask

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_ch     = 2'd0;
        cfg_div    = 8'd0;
        ch_gate_en = '1;

        // Reset held for edges 1..3, released so edge 4 enters HOLD.
        for (int c = 1; c <= 3; c++) push_reset_vals(c);
        push_seq(4, 1000);
        for (int c = 6; c <= 12; c++) push(c, K_CEV, 0, 4'hF);
        to_cyc(3);
        rst = 1'b0;

        // Channel 2 to N=5, accepted at edge 41.
        to_cyc(40);
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd5;
        for (int c = 41; c <= 60; c++) begin
            push(c, K_CE, 2, {3'b000, (c > 41) && ((c - 41) % 5 == 0)});
            push(c, K_CLK, 2, {3'b000, ((c - 41) / 5) % 2 == 1});
        end
        for (int c = 41; c <= 45; c++) push(c, K_CE, 0, 4'h1);
        to_cyc(41);
        cfg_valid = 1'b0;

        // Channel 2 to N=0 on its terminal-count cycle (edge 61).
        to_cyc(60);
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0;
        push(61, K_CE, 2, 4'h0);
        push(61, K_CLK, 2, 4'h1);
        for (int c = 62; c <= 68; c++) begin
            push(c, K_CE, 2, 4'h1);
            push(c, K_CLK, 2, {3'b000, (c - 61) % 2 == 0});
        end
        to_cyc(61);
        cfg_valid = 1'b0;

        // Channel 1 to N=3, then N=4 landing on a terminal count at edge 80.
        to_cyc(70);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
        for (int c = 71; c <= 79; c++) push(c, K_CE, 1, {3'b000, c == 74 || c == 77});
        to_cyc(71);
        cfg_valid = 1'b0;
        to_cyc(79);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd4;
        for (int c = 80; c <= 88; c++) push(c, K_CE, 1, {3'b000, c == 84 || c == 88});
        push(80, K_READY, 0, 4'h1);
        to_cyc(80);
        cfg_valid = 1'b0;

        // Full reset, then re-assert during STAGGER after two releases.
        to_cyc(90);
        rst = 1'b1;
        for (int c = 91; c <= 93; c++) push_reset_vals(c);
        to_cyc(93);
        rst = 1'b0;
        push_seq(94, 116);
        to_cyc(115);
        rst = 1'b1;
        push_reset_vals(116);
        to_cyc(117);
        rst = 1'b0;
        push_seq(118, 1000);
        for (int c = 120; c <= 124; c++) push(c, K_CEV, 0, 4'hF);

`ifdef CLK_RST_GEN_GATE_EN
        // Channel 1 at N=3, gated off for edges 166..172.
        to_cyc(160);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
        for (int c = 161; c <= 180; c++) begin
            push(c, K_CE, 1, {3'b000, c == 164 || c == 174 || c == 177 || c == 180});
            push(c, K_CLK, 1, {3'b000, (c >= 164 && c <= 173) || (c >= 177 && c <= 179)});
        end
        push(170, K_RSTN, 0, 4'hF);
        to_cyc(161);
        cfg_valid = 1'b0;
        to_cyc(165);
        ch_gate_en[1] = 1'b0;
        to_cyc(172);
        ch_gate_en[1] = 1'b1;
`endif

        to_cyc(185);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d pending expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
